// File: rtl/pc_pkg.sv
// pc_pkg -- shared definitions for the fetch-stage program counter.
//
// Contents:
//   pc_src_e            encoding of the source that produced the current pc
//   DEFAULT_ADDR_W      default address width shared with imem and hazard units
//   DEFAULT_RESET_ADDR  default reset fetch address
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD   = 3'd0,
    PC_SEQ    = 3'd1,
    PC_RAS    = 3'd2,
    PC_BRANCH = 3'd3,
    PC_TRAP   = 3'd4
  } pc_src_e;

  localparam int          DEFAULT_ADDR_W     = 32;
  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

endpackage

// File: rtl/pc_gen_ras.sv
// ras_stack -- circular return-address stack for pc_gen.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset (count cleared)
//   clear      in   drop all entries (trap)
//   push       in   push push_data
//   pop        in   pop the top entry (ignored when empty)
//   push_data  in   ADDR_W  value to push
//   top        out  ADDR_W  current top entry (valid when !empty)
//   empty      out  registered: no entries held
//   full       out  registered: RAS_DEPTH entries held
//
// A push while full overwrites the oldest entry. push and pop together on a
// non-empty stack replace the top entry in place; on an empty stack only the
// push happens.
module ras_stack #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;   // next slot to write; top lives one below
  logic [PTR_W-1:0]  top_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_d;
  logic              do_pop;

  assign top_ptr = wr_ptr - PTR_W'(1);
  assign top     = mem[top_ptr];
  assign do_pop  = pop && (count != '0);

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count;
    if (clear)
      count_d = '0;
    else if (push && !do_pop && (count != DEPTH_CNT))
      count_d = count + CNT_W'(1);
    else if (do_pop && !push)
      count_d = count - CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      count <= count_d;
      empty <= (count_d == '0);
      full  <= (count_d == DEPTH_CNT);
      if (clear)
        wr_ptr <= '0;
      else if (push && !do_pop)
        wr_ptr <= wr_ptr + PTR_W'(1);
      else if (do_pop && !push)
        wr_ptr <= wr_ptr - PTR_W'(1);
    end
  end

  // NOTE: the storage array is not reset; count alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (!reset && !clear && push)
      mem[do_pop ? top_ptr : wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen -- fetch-stage program counter generator.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   synchronous active-high reset
//   stall          in   hold pc (and RAS) this cycle
//   trap           in   exception request, highest priority
//   trap_vector    in   ADDR_W  trap target
//   redirect       in   taken branch/jump from execute
//   redirect_addr  in   ADDR_W  redirect target
//   call           in   instruction at pc is a call (push pc+STEP)
//   ret            in   instruction at pc is a return (pop prediction)
//   pc             out  ADDR_W  current fetch address (registered)
//   pc_valid       out  pc is fetchable
//   pc_src         out  3  pc_src_e of the last update
//   ras_empty      out  RAS holds no entries
//   ras_full       out  RAS holds RAS_DEPTH entries
//
// Build option: define PC_RAS_EN to build the return-address stack. Without
// it call/ret are ignored, ras_empty is tied 1 and ras_full tied 0.
//
// Priority: trap > redirect > stall > ret (RAS non-empty) > sequential.
// The first edge after reset only raises pc_valid so the instruction at
// RESET_ADDR is fetched without starting from RESET_ADDR-STEP.
module pc_gen
  import pc_pkg::*;
#(
  parameter int                ADDR_W     = DEFAULT_ADDR_W,
  parameter int                STEP       = 1,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(DEFAULT_RESET_ADDR),
  parameter int                RAS_DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              trap,
  input  logic [ADDR_W-1:0] trap_vector,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic [2:0]        pc_src,
  output logic              ras_empty,
  output logic              ras_full
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_seq;
  pc_src_e           src_q;
  pc_src_e           src_d;
  logic              valid_q;

  // Wraps modulo 2^ADDR_W.
  assign pc_seq = pc_q + ADDR_W'(STEP);

`ifdef PC_RAS_EN
  logic [ADDR_W-1:0] ras_top;
  logic              advance;

  // call/ret only act on cycles that fall through to the low-priority cases.
  assign advance = valid_q && !trap && !redirect && !stall;

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .clear     (valid_q && trap),
    .push      (advance && call),
    .pop       (advance && ret),
    .push_data (pc_seq),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_ras_inputs;
  assign unused_ras_inputs = call ^ ret;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
`endif

  always_comb begin
    pc_d  = pc_q;
    src_d = PC_HOLD;
    if (!valid_q) begin
      pc_d  = pc_q;
      src_d = PC_HOLD;
    end else if (trap) begin
      pc_d  = trap_vector;
      src_d = PC_TRAP;
    end else if (redirect) begin
      pc_d  = redirect_addr;
      src_d = PC_BRANCH;
    end else if (stall) begin
      pc_d  = pc_q;
      src_d = PC_HOLD;
    end
`ifdef PC_RAS_EN
    else if (ret && !ras_empty) begin
      pc_d  = ras_top;
      src_d = PC_RAS;
    end
`endif
    else begin
      pc_d  = pc_seq;
      src_d = PC_SEQ;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_ADDR;
      src_q   <= PC_HOLD;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      src_q   <= src_d;
      valid_q <= 1'b1;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = valid_q;
  assign pc_src   = src_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen -- directed self-checking bench for pc_gen.
// Main instance: defaults (ADDR_W=32, STEP=1). Second instance: ADDR_W=8,
// STEP=4 for the narrow wrap case. RAS scenarios follow the PC_RAS_EN build.
module tb_pc_gen;
  import pc_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0, trap = 1'b0, redirect = 1'b0, call = 1'b0, ret = 1'b0;
  logic [31:0] trap_vector = '0, redirect_addr = '0;
  logic [31:0] pc;
  logic        pc_valid, ras_empty, ras_full;
  logic [2:0]  pc_src;

  logic        s_redirect = 1'b0;
  logic [7:0]  s_redirect_addr = '0;
  logic [7:0]  s_pc;
  logic        s_pc_valid, s_ras_empty, s_ras_full;
  logic [2:0]  s_pc_src;

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  pc_gen dut (
    .clock(clock), .reset(reset), .stall(stall), .trap(trap),
    .trap_vector(trap_vector), .redirect(redirect), .redirect_addr(redirect_addr),
    .call(call), .ret(ret), .pc(pc), .pc_valid(pc_valid), .pc_src(pc_src),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  pc_gen #(.ADDR_W(8), .STEP(4), .RESET_ADDR(8'h00)) dut_small (
    .clock(clock), .reset(reset), .stall(1'b0), .trap(1'b0),
    .trap_vector(8'h00), .redirect(s_redirect), .redirect_addr(s_redirect_addr),
    .call(1'b0), .ret(1'b0), .pc(s_pc), .pc_valid(s_pc_valid), .pc_src(s_pc_src),
    .ras_empty(s_ras_empty), .ras_full(s_ras_full)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Compare {pc_valid, pc, pc_src} against an expected triple.
  task automatic expect_pc(input string name, input logic [31:0] exp_pc, input pc_src_e exp_src);
    tests++;
    if ({pc_valid, pc, pc_src} !== {1'b1, exp_pc, 3'(exp_src)}) begin
      failed++;
      $display("FAIL %s: valid=%0b pc=0x%0h src=%0d, expected valid=1 pc=0x%0h src=%0d",
               name, pc_valid, pc, pc_src, exp_pc, exp_src);
    end
  endtask

  task automatic expect_ras(input string name, input logic exp_empty, input logic exp_full);
    tests++;
    if ({ras_empty, ras_full} !== {exp_empty, exp_full}) begin
      failed++;
      $display("FAIL %s: ras_empty=%0b ras_full=%0b, expected %0b %0b",
               name, ras_empty, ras_full, exp_empty, exp_full);
    end
  endtask

  task automatic jump(input logic [31:0] addr);
    redirect = 1'b1; redirect_addr = addr;
    step();
    redirect = 1'b0;
    expect_pc("jump", addr, PC_BRANCH);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({pc_valid, pc, pc_src, ras_empty, ras_full} !== {1'b0, 32'h0, 3'(PC_HOLD), 1'b1, 1'b0}) begin
        failed++;
        $display("FAIL reset_state: valid=%0b pc=0x%0h src=%0d empty=%0b full=%0b, expected 0 0x0 0 1 0",
                 pc_valid, pc, pc_src, ras_empty, ras_full);
      end
    end
    reset = 1'b0;
    step();
    expect_pc("first_fetch", 32'h0, PC_HOLD);
    for (int i = 1; i <= 3; i++) begin
      step();
      expect_pc("sequential", 32'(i), PC_SEQ);
    end
  endtask

  task automatic test_stall_redirect();
    step(); step();
    expect_pc("seq_to_5", 32'h5, PC_SEQ);
    stall = 1'b1;
    step();
    expect_pc("stall_hold", 32'h5, PC_HOLD);
    redirect = 1'b1; redirect_addr = 32'h40;
    step();
    redirect = 1'b0;
    expect_pc("redirect_over_stall", 32'h40, PC_BRANCH);
    step();
    expect_pc("stall_after_redirect", 32'h40, PC_HOLD);
    stall = 1'b0;
    step();
    expect_pc("resume_seq", 32'h41, PC_SEQ);
  endtask

  task automatic test_wrap();
    s_redirect = 1'b1; s_redirect_addr = 8'hFC;
    redirect = 1'b1; redirect_addr = 32'hFFFF_FFFF;
    step();
    s_redirect = 1'b0; redirect = 1'b0;
    expect_pc("redirect_all_ones", 32'hFFFF_FFFF, PC_BRANCH);
    tests++;
    if ({s_pc, s_pc_src} !== {8'hFC, 3'(PC_BRANCH)}) begin
      failed++;
      $display("FAIL small_redirect: pc=0x%0h src=%0d, expected 0xfc 3", s_pc, s_pc_src);
    end
    step();
    expect_pc("wrap32", 32'h0, PC_SEQ);
    tests++;
    if ({s_pc_valid, s_pc, s_pc_src, s_ras_empty, s_ras_full} !== {1'b1, 8'h00, 3'(PC_SEQ), 1'b1, 1'b0}) begin
      failed++;
      $display("FAIL small_wrap: valid=%0b pc=0x%0h src=%0d, expected valid=1 pc=0x0 src=1",
               s_pc_valid, s_pc, s_pc_src);
    end
  endtask

`ifdef PC_RAS_EN
  task automatic test_ras_calls();
    jump(32'd10);
    call = 1'b1; step(); call = 1'b0;
    expect_pc("call_at_10", 32'd11, PC_SEQ);
    jump(32'd20);
    call = 1'b1; step(); call = 1'b0;
    jump(32'd30);
    call = 1'b1; step(); call = 1'b0;
    expect_ras("three_pushed", 1'b0, 1'b0);
    ret = 1'b1;
    step(); expect_pc("ret_1", 32'd31, PC_RAS);
    step(); expect_pc("ret_2", 32'd21, PC_RAS);
    step(); expect_pc("ret_3", 32'd11, PC_RAS);
    expect_ras("ras_drained", 1'b1, 1'b0);
    step(); expect_pc("ret_on_empty", 32'd12, PC_SEQ);
    ret = 1'b0;
  endtask

  task automatic test_ras_overflow();
    jump(32'h200);
    call = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 3) expect_ras("three_of_four", 1'b0, 1'b0);
      if (i == 4) expect_ras("full_after_4", 1'b0, 1'b1);
    end
    call = 1'b0;
    expect_ras("full_after_5", 1'b0, 1'b1);
    ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_pc("overflow_pop", 32'h205 - 32'(i), PC_RAS);
    end
    expect_ras("empty_after_4_pops", 1'b1, 1'b0);
    step();
    expect_pc("fifth_ret_seq", 32'h203, PC_SEQ);
    ret = 1'b0;
  endtask

  task automatic test_call_ret_trap();
    jump(32'h300);
    call = 1'b1; step();
    expect_pc("push_0x301", 32'h301, PC_SEQ);
    ret = 1'b1; step();
    expect_pc("call_ret_nonempty", 32'h301, PC_RAS);
    expect_ras("count_unchanged", 1'b0, 1'b0);
    call = 1'b0; step();
    expect_pc("replaced_top", 32'h302, PC_RAS);
    expect_ras("empty_after_pop", 1'b1, 1'b0);
    call = 1'b1; step();
    expect_pc("call_ret_empty", 32'h303, PC_SEQ);
    expect_ras("push_only", 1'b0, 1'b0);
    call = 1'b0; ret = 1'b0;
    trap = 1'b1; trap_vector = 32'h800; redirect = 1'b1; redirect_addr = 32'h40;
    step();
    trap = 1'b0; redirect = 1'b0;
    expect_pc("trap_over_redirect", 32'h800, PC_TRAP);
    expect_ras("trap_clears_ras", 1'b1, 1'b0);
  endtask
`else
  task automatic test_no_ras();
    jump(32'h300);
    call = 1'b1; step(); call = 1'b0;
    ret = 1'b1; step(); ret = 1'b0;
    expect_pc("ret_ignored", 32'h302, PC_SEQ);
    expect_ras("ras_tied", 1'b1, 1'b0);
    trap = 1'b1; trap_vector = 32'h800; redirect = 1'b1; redirect_addr = 32'h40; stall = 1'b1;
    step();
    trap = 1'b0; redirect = 1'b0; stall = 1'b0;
    expect_pc("trap_over_redirect", 32'h800, PC_TRAP);
  endtask
`endif

  task automatic test_reset_mid();
    step();
    expect_pc("post_trap_seq", 32'h801, PC_SEQ);
    reset = 1'b1; trap = 1'b1; trap_vector = 32'h900;
    step();
    tests++;
    if ({pc_valid, pc, pc_src, ras_empty} !== {1'b0, 32'h0, 3'(PC_HOLD), 1'b1}) begin
      failed++;
      $display("FAIL reset_over_trap: valid=%0b pc=0x%0h src=%0d empty=%0b, expected 0 0x0 0 1",
               pc_valid, pc, pc_src, ras_empty);
    end
    reset = 1'b0; trap = 1'b0;
    step();
    expect_pc("refetch_reset_addr", 32'h0, PC_HOLD);
    step();
    expect_pc("restart_seq", 32'h1, PC_SEQ);
  endtask

  initial begin
    test_reset();
    test_stall_redirect();
    test_wrap();
`ifdef PC_RAS_EN
    test_ras_calls();
    test_ras_overflow();
    test_call_ret_trap();
`else
    test_no_ras();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
